// File: rtl/mod.sv
// mod: signed operand reduced modulo a runtime modulus via a sequential restoring divider.
// Optional MOD_ERR_EN adds an err output flagging modulus==0 or modulus>2**RW.
module mod #(
    parameter int W  = 8,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  modulus,
    output logic          out_valid,
    output logic [W-1:0]  x_,
    output logic [RW-1:0] x_mod
`ifdef MOD_ERR_EN
    ,
    output logic          err
`endif
);
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0] MMAX = W'(2 ** RW);
    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [W:0]    rem, sh, step;
    logic [W-1:0]  mag, dvd, m, ax;
    logic [RW-1:0] rf;
    logic          neg, bad;
    assign ax       = x[W-1] ? W'(-x) : x;
    assign in_ready = state == IDLE;
    assign sh       = {rem[W-1:0], dvd[W-1]};
    assign step     = (m != 0 && sh >= {1'b0, m}) ? sh - {1'b0, m} : sh;
    // negative operands fold back into [0, m-1]; an exact multiple stays at 0
    assign rf       = (neg && rem != 0) ? RW'({1'b0, m} - rem) : RW'(rem);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = in_valid ? DIV : IDLE;
            DIV:     nxt = (cnt == CW'(W)) ? FIX : DIV;
            default: nxt = IDLE;
        endcase
    end
    // the first DIV cycle clears the remainder and classifies the modulus; W shift steps follow
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            x_        <= '0;
            x_mod     <= '0;
            cnt       <= '0;
            rem       <= '0;
            mag       <= '0;
            dvd       <= '0;
            m         <= '0;
            neg       <= 1'b0;
            bad       <= 1'b0;
`ifdef MOD_ERR_EN
            err       <= 1'b0;
`endif
        end else begin
            state     <= nxt;
            out_valid <= 1'b0;
            if (state == IDLE && in_valid) begin
                neg <= x[W-1];
                mag <= ax;
                dvd <= ax;
                m   <= modulus;
                cnt <= '0;
            end
            if (state == DIV) begin
                cnt <= cnt + 1'b1;
                if (cnt == 0) begin
                    rem <= '0;
                    bad <= (m == 0) || (m > MMAX);
                end else begin
                    rem <= step;
                    dvd <= dvd << 1;
                end
            end
            if (state == FIX) begin
                x_mod     <= bad ? '0 : rf;
                x_        <= mag;
                out_valid <= 1'b1;
`ifdef MOD_ERR_EN
                err       <= bad;
`endif
            end
        end
    end
endmodule

// File: tb/tb_mod.sv
// tb_mod: directed table plus randomized operands checked against an arithmetic residue model.
module tb_mod;
    logic       clk = 0, rst = 1, in_valid = 0;
    logic       in_ready, out_valid;
    logic [7:0] x = 0, modulus = 0, x_;
    logic [4:0] x_mod;
    logic       err;
    int         n_vec = 0, n_bad = 0;
    always #5 clk = ~clk;
`ifdef MOD_ERR_EN
    mod dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
             .modulus(modulus), .out_valid(out_valid), .x_(x_), .x_mod(x_mod), .err(err));
`else
    assign err = 1'b0;
    mod dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
             .modulus(modulus), .out_valid(out_valid), .x_(x_), .x_mod(x_mod));
`endif
    typedef struct {int xv; int m; int e_abs; int e_mod; int e_err;} vec_t;
    vec_t tbl[15];
    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask
    function automatic int ref_mod(input int xv, input int m);
        if (m == 0 || m > 32) return 0;
        return ((xv % m) + m) % m;
    endfunction
    task automatic run_op(input int xv, input int m, input int e_abs, input int e_mod,
                          input int e_err, input bit busy_pulse, input string tag);
        int lat;
        logic [4:0] held;
        @(negedge clk);
        chk({tag, " in_ready"}, int'(in_ready), 1);
        in_valid = 1; x = 8'(xv); modulus = 8'(m);
        @(posedge clk); #1;
        in_valid = 0;
        lat = 0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (busy_pulse && lat == 3) begin in_valid = 1; x = 8'd7; modulus = 8'd3; end
            if (busy_pulse && lat == 6) in_valid = 0;
            if (out_valid || lat >= 30) break;
        end
        chk({tag, " latency"}, lat, 10);
        chk({tag, " x_"}, int'(x_), e_abs);
        chk({tag, " x_mod"}, int'(x_mod), e_mod);
`ifdef MOD_ERR_EN
        chk({tag, " err"}, int'(err), e_err);
`endif
        held = x_mod;
        @(posedge clk); #1;
        chk({tag, " pulse"}, int'(out_valid), 0);
        chk({tag, " hold"}, int'(x_mod), int'(held));
    endtask
    initial begin
        tbl = '{
            '{-1, 17, 1, 16, 0}, '{-2, 17, 2, 15, 0}, '{-3, 17, 3, 14, 0},
            '{3, 17, 3, 3, 0},   '{30, 17, 30, 13, 0}, '{-17, 17, 17, 0, 0},
            '{-128, 17, 128, 8, 0}, '{0, 17, 0, 0, 0}, '{5, 0, 5, 0, 1},
            '{5, 1, 5, 0, 0},    '{127, 32, 127, 31, 0}, '{-1, 32, 1, 31, 0},
            '{5, 33, 5, 0, 1},   '{-128, 32, 128, 0, 0}, '{-35, 5, 35, 0, 0}};
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset x_", int'(x_), 0);
        chk("reset x_mod", int'(x_mod), 0);
        chk("reset err", int'(err), 0);
        @(negedge clk); rst = 0;
        foreach (tbl[i])
            run_op(tbl[i].xv, tbl[i].m, tbl[i].e_abs, tbl[i].e_mod, tbl[i].e_err, 0,
                   $sformatf("vec%0d", i));
        run_op(-1, 17, 1, 16, 0, 1, "busy_ignored");
        @(negedge clk);
        in_valid = 1; x = 8'd30; modulus = 8'd17;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        chk("abort out_valid", int'(out_valid), 0);
        chk("abort in_ready", int'(in_ready), 1);
        @(negedge clk); rst = 0;
        begin
            int seen = 0;
            repeat (15) begin @(posedge clk); #1; if (out_valid) seen++; end
            chk("abort no result", seen, 0);
        end
        for (int i = 0; i < 200; i++) begin
            int xv, m, av;
            xv = int'($signed(8'($urandom)));
            m  = (i % 10 == 0) ? int'($urandom_range(33, 255)) : int'($urandom_range(0, 34));
            av = xv < 0 ? -xv : xv;
            run_op(xv, m, av, ref_mod(xv, m), (m == 0 || m > 32) ? 1 : 0, i % 7 == 0,
                   $sformatf("rnd%0d x=%0d m=%0d", i, xv, m));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
